write_through_buffer: RTL
=========================

# write_through_buffer

Posted-write FIFO and memory-port arbiter between the write-through cache controller and the 4-word-block main memory. Write-through stores are queued and drained to memory one word at a time; block-refill reads are serialized behind the queue so memory is never read stale. A simple level handshake on the memory side: each request is held until `mem_ready`, then released for one idle cycle.

## Interface
- `WIDTH`, 32, data word width
- `ADDR_WIDTH`, 10, word address width (memory depth 2^ADDR_WIDTH)
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low
- `wr_req` in 1: store request from cache controller
- `wr_addr` in ADDR_WIDTH: store word address
- `wr_data` in WIDTH: store data
- `wr_full` out 1: FIFO full; push ignored while high
- `wr_empty` out 1: FIFO empty and no write in flight
- `rd_req` in 1: refill request, level, held until `rd_valid`
- `rd_addr` in ADDR_WIDTH: refill address; low 2 bits ignored
- `rd_valid` out 1: one-cycle pulse, refill block on `rd_data`
- `rd_data` out 4*WIDTH: refill block, held until next refill completes
- `mem_address` out ADDR_WIDTH: memory address
- `mem_write_en` out 1: memory write request
- `mem_read_en` out 1: memory block-read request
- `mem_write_data` out WIDTH: memory write data
- `mem_ready` in 1: memory completion
- `mem_read_data` in 4*WIDTH: memory block data

## Operation
- FIFO: DEPTH entries of {addr, data}; ADDR_WIDTH-bit-agnostic pointers of log2(DEPTH) bits wrap naturally; count of log2(DEPTH)+1 bits.
- Push: `wr_req && !wr_full` stores entry at edge. Push while full is dropped; controller must hold `wr_req`.
- Push and pop in the same cycle allowed when not full; count unchanged.
- States: IDLE, WRITE, READ, GAP.
- IDLE: count>0 → WRITE (load head entry into `mem_address`/`mem_write_data`, `mem_write_en`=1). Else `rd_req` → READ (`mem_address`={rd_addr[ADDR_WIDTH-1:2],2'b00}, `mem_read_en`=1). Writes always win over reads.
- WRITE: hold outputs until `mem_ready`=1; at that edge pop head, `mem_write_en`=0, → GAP.
- READ: hold until `mem_ready`=1; at that edge capture `mem_read_data` into `rd_data`, pulse `rd_valid`, `mem_read_en`=0, → GAP.
- GAP: exactly one cycle, both enables low, `mem_ready` ignored; → IDLE.
- A refill requested while writes are queued waits until FIFO drains, including stores pushed while waiting (read-after-write ordering).
- `mem_write_en` and `mem_read_en` never both high.
- `wr_empty` = count==0 and state≠WRITE.

## Timing
- All outputs registered.
- Reset values: `wr_full`=0, `wr_empty`=1, `rd_valid`=0, `rd_data`=0, `mem_address`=0, `mem_write_en`=0, `mem_read_en`=0, `mem_write_data`=0; state IDLE, pointers and count 0.
- Push at edge N → `wr_full`/`wr_empty` reflect it after edge N; `mem_write_en` rises at edge N+1 earliest (IDLE→WRITE).
- Write occupancy: 1 (issue) + memory latency + 1 (GAP) cycles; back-to-back writes spaced by GAP.
- Refill: `rd_valid` high the cycle after the edge sampling `mem_ready` in READ; controller drops `rd_req` after seeing `rd_valid`. `rd_req` still high in IDLE after GAP starts a new refill.
- Reset mid-operation: at the next edge all queued entries discarded, enables dropped, state IDLE; an in-progress memory transaction is abandoned.
- `rd_addr`/`wr_*` changes while not accepted have no effect.

## Test plan
- Reset: assert `reset`=0 for 2 cycles mid-WRITE with 3 entries queued → all outputs at reset values, `wr_empty`=1, no further `mem_write_en`.
- Single store: push addr 0x010, data 0xDEADBEEF; memory ready after 1 cycle → `mem_write_en` one request with 0x010/0xDEADBEEF, then GAP, `wr_empty`=1.
- Full: push 5 stores back-to-back with `mem_ready` stuck 0 → `wr_full`=1 after 4th, 5th dropped until first pop; all 5 reach memory in order once held.
- Simultaneous push/pop at count 3 → count stays 3, order preserved, pointer wrap past entry 3→0 correct.
- Read behind writes: 2 stores queued then `rd_req` addr 0x013 → both writes issued first, then `mem_read_en` with `mem_address`=0x010; `rd_data` equals memory block incl. just-written words, `rd_valid` one cycle.
- Enables exclusive: random stores/refills with random memory latency 0–5 → never both enables high, GAP always one cycle between requests.

Source files
------------

// File: rtl/write_through_buffer.sv
// Posted-write FIFO plus memory-port arbiter for a write-through cache.
// Stores drain one word at a time; block refills wait behind queued stores.
module write_through_buffer #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    wr_full,
    output logic                    wr_empty,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_valid,
    output logic [4*WIDTH-1:0]      rd_data,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_write_en,
    output logic                    mem_read_en,
    output logic [WIDTH-1:0]        mem_write_data,
    input  logic                    mem_ready,
    input  logic [4*WIDTH-1:0]      mem_read_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
    localparam logic [PW:0]           CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]           CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~(ADDR_WIDTH'(3));

    typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fifo_addr_q [DEPTH];
    logic [WIDTH-1:0]        fifo_data_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]             count_q, count_d;
    logic                    wr_full_q, wr_full_d, wr_empty_q, wr_empty_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [4*WIDTH-1:0]      rd_data_q, rd_data_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic                    mem_write_en_q, mem_write_en_d;
    logic                    mem_read_en_q, mem_read_en_d;
    logic [WIDTH-1:0]        mem_write_data_q, mem_write_data_d;
    logic                    push, pop;

    assign push = wr_req && !wr_full_q;

    always_comb begin
        state_d          = state_q;
        pop              = 1'b0;
        rd_valid_d       = 1'b0;
        rd_data_d        = rd_data_q;
        mem_address_d    = mem_address_q;
        mem_write_en_d   = mem_write_en_q;
        mem_read_en_d    = mem_read_en_q;
        mem_write_data_d = mem_write_data_q;
        case (state_q)
            IDLE: begin
                // Queued stores always drain before a refill is issued
                if (count_q != '0) begin
                    state_d          = WRITE;
                    mem_address_d    = fifo_addr_q[rd_ptr_q];
                    mem_write_data_d = fifo_data_q[rd_ptr_q];
                    mem_write_en_d   = 1'b1;
                end else if (rd_req) begin
                    state_d       = READ;
                    mem_address_d = rd_addr & BLK_MASK;
                    mem_read_en_d = 1'b1;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    pop            = 1'b1;
                    mem_write_en_d = 1'b0;
                    state_d        = GAP;
                end
            end
            READ: begin
                if (mem_ready) begin
                    rd_data_d     = mem_read_data;
                    rd_valid_d    = 1'b1;
                    mem_read_en_d = 1'b0;
                    state_d       = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        wr_full_d  = (count_d == CNT_FULL);
        wr_empty_d = (count_d == '0) && (state_d != WRITE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            wr_full_q        <= 1'b0;
            wr_empty_q       <= 1'b1;
            rd_valid_q       <= 1'b0;
            rd_data_q        <= '0;
            mem_address_q    <= '0;
            mem_write_en_q   <= 1'b0;
            mem_read_en_q    <= 1'b0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            wr_full_q        <= wr_full_d;
            wr_empty_q       <= wr_empty_d;
            rd_valid_q       <= rd_valid_d;
            rd_data_q        <= rd_data_d;
            mem_address_q    <= mem_address_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_read_en_q    <= mem_read_en_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    // Entry storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_full        = wr_full_q;
    assign wr_empty       = wr_empty_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign mem_address    = mem_address_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_read_en    = mem_read_en_q;
    assign mem_write_data = mem_write_data_q;

endmodule
